datapath_pipe: RTL and testbench
================================

Name: datapath_pipe

Overview:
- Parametrised successor of the team's 8-bit, 4-register datapath: configurable width and register count, one write-back pipeline stage with operand forwarding, and registered status flags with a load-enable.
- Sits between the control unit (decoded DA/AA/BA/FS/MB/MD/RW) and data memory.
- The memory interface (address, store data, load data) and the jump-address output keep the same roles as in the current datapath.

Parameters:
- W, 8, data width in bits (>=4).
- AW, 2, register address width; register file depth = 2**AW.
- R0_ZERO, 0, 1 = register 0 reads as zero and ignores writes.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operation issued this cycle.
- rw  in  1  register write enable for the issued operation.
- da, aa, ba  in  AW  destination, A-source and B-source register addresses.
- mb  in  1  B-operand select: 0 = register B, 1 = constant_in.
- md  in  1  write-back select: 0 = function-unit result, 1 = data_in_mem.
- fs  in  4  function select.
- fl_en  in  1  load V/C/N/Z from this operation.
- constant_in  in  W  immediate operand.
- data_in_mem  in  W  load data from memory; must be valid in the issue cycle.
- address_out  out  W  memory address = A operand (combinational).
- data_out  out  W  store data = selected B operand (combinational).
- jump_address  out  W  = A operand (combinational).
- wb_data  out  W  registered write-back value.
- wb_valid  out  1  registered: a write-back is pending this cycle.
- v, c, n, z  out  1  registered status flags.

Behaviour:
Reset (async):
- All registers, wb_data, wb_valid, internal wb_da/wb_rw and v/c/n/z clear to 0 immediately and stay 0 while rst is high.
- A reset arriving mid-operation discards any pending write-back; that write never reaches the register file.

Operands:
- A operand = forwarded value if forwarding hits, else reg[aa].
- Bsel = constant_in if mb = 1; otherwise forwarded value if hit, else reg[ba].
- Forwarding hits when wb_valid & wb_rw & (wb_da == source address), and also (R0_ZERO = 0 or source != 0). Forwarding takes priority over register file contents.

Function unit (combinational, all arithmetic W+1 bits):
- 0000: A. 0001: A+1. 0010: A+B. 0011: A+B+1. 0100: A+~B. 0101: A+~B+1 (A-B). 0110: A-1. 0111: A.
- 1000: A&B. 1001: A|B. 1010: A^B. 1011: ~A.
- 1100: B. 1101: B>>1, zero fill. 1110: B<<1, zero fill. 1111: 0.
- C = bit W of the sum for arithmetic codes (0000-0111), else 0.
- V = signed overflow of the arithmetic codes: operands are the actual adder inputs (A with B, ~B or the constant 1 / all-ones), and V = 1 when their sign bits are equal and the result sign differs. V = 0 for all other codes.
- N = result[W-1]. Z = (result == 0).

Issue cycle t (in_valid = 1):
- result = md ? data_in_mem : FU result.
- At edge ending t: wb_data <= result, wb_da <= da, wb_rw <= rw, wb_valid <= 1.
- With in_valid = 0: wb_valid <= 0; wb_data, wb_da and wb_rw hold.

Flags:
- Updated at edge ending t only if in_valid & fl_en; otherwise hold.
- Flags always come from the FU, independent of md.

Write-back (cycle t+1):
- At edge ending t+1, reg[wb_da] <= wb_data if wb_valid & wb_rw, and not (R0_ZERO & wb_da == 0).
- Back-to-back dependent ops need no stall: op at t+1 sees the result by forwarding; op at t+2 reads it from the register file.
- Same-address write-back and new issue in the same cycle: the register file takes the old wb value, and the wb stage takes the new one (both happen).
- Writes of the same register on consecutive cycles: the later value wins.

Test Plan:
- rst pulse asynchronous to clk, with prior writes -> registers, wb_valid and flags read 0 immediately; first op after release reads R1 = 0.
- W=8: issue R1 <= const 0x7F (fs=1100, mb=1), then R2 <= R1+1 (fs=0001, fl_en=1) on the next cycle -> forwarded A = 0x7F, wb_data = 0x80, V=1, C=0, N=1, Z=0.
- R1 = 0x05, R2 = 0x05: issue fs=0101 on R1,R2 with fl_en=1, rw=0 -> Z=1, C=1, N=0, V=0, registers unchanged; the next op with fl_en=0 leaves flags held.
- md=1, data_in_mem = 0xA5, da=3, then read R3 two cycles later (no forwarding) -> 0xA5; address_out = A operand in the issue cycle.
- R0_ZERO=1: write 0xFF to R0, then read R0 on the following cycle and two cycles later -> 0x00 both times, with no forwarding hit.
- Reset asserted while wb_valid=1 targeting R2 = 0x33 -> R2 remains 0 after reset release.

Source files
------------

// File: rtl/datapath_pipe.sv
// Register-file datapath: registered write-back one cycle after issue, committed to the register file the cycle after.
// Forwarding from the write-back stage removes dependent-op stalls; no backpressure, one op accepted per cycle.
module datapath_pipe #(
    parameter int W       = 8,
    parameter int AW      = 2,
    parameter bit R0_ZERO = 1'b0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    input  logic          rw,
    input  logic [AW-1:0] da,
    input  logic [AW-1:0] aa,
    input  logic [AW-1:0] ba,
    input  logic          mb,
    input  logic          md,
    input  logic [3:0]    fs,
    input  logic          fl_en,
    input  logic [W-1:0]  constant_in,
    input  logic [W-1:0]  data_in_mem,
    output logic [W-1:0]  address_out,
    output logic [W-1:0]  data_out,
    output logic [W-1:0]  jump_address,
    output logic [W-1:0]  wb_data,
    output logic          wb_valid,
    output logic          v,
    output logic          c,
    output logic          n,
    output logic          z
);
    localparam int DEPTH = 1 << AW;

    logic [W-1:0]  regs [DEPTH];
    logic [AW-1:0] wb_da;
    logic          wb_rw;
    logic          wb_we;

    logic          hit_a;
    logic          hit_b;
    logic [W-1:0]  rf_a;
    logic [W-1:0]  rf_b;
    logic [W-1:0]  a_op;
    logic [W-1:0]  b_reg;
    logic [W-1:0]  b_sel;

    logic [W-1:0]  add_y;
    logic          add_cin;
    logic [W:0]    sum;
    logic [W-1:0]  fu_res;
    logic          fu_v;
    logic          fu_c;
    logic [W-1:0]  result;

    // A pending write to a hard-wired zero register must never be forwarded.
    assign hit_a = wb_valid && wb_rw && (wb_da == aa) && (!R0_ZERO || (aa != '0));
    assign hit_b = wb_valid && wb_rw && (wb_da == ba) && (!R0_ZERO || (ba != '0));

    assign rf_a  = (R0_ZERO && (aa == '0)) ? '0 : regs[aa];
    assign rf_b  = (R0_ZERO && (ba == '0)) ? '0 : regs[ba];

    assign a_op  = hit_a ? wb_data : rf_a;
    assign b_reg = hit_b ? wb_data : rf_b;
    assign b_sel = mb ? constant_in : b_reg;

    assign address_out  = a_op;
    assign jump_address = a_op;
    assign data_out     = b_sel;

    // Every arithmetic code is A + add_y + add_cin; V/C come from that single adder.
    always_comb begin
        add_y   = '0;
        add_cin = 1'b0;
        case (fs[2:0])
            3'b001:  add_y = W'(1);
            3'b010:  add_y = b_sel;
            3'b011: begin
                add_y   = b_sel;
                add_cin = 1'b1;
            end
            3'b100:  add_y = ~b_sel;
            3'b101: begin
                add_y   = ~b_sel;
                add_cin = 1'b1;
            end
            3'b110:  add_y = '1;
            default: add_y = '0;
        endcase
    end

    assign sum = {1'b0, a_op} + {1'b0, add_y} + {{W{1'b0}}, add_cin};

    always_comb begin
        fu_res = '0;
        fu_c   = 1'b0;
        fu_v   = 1'b0;
        if (!fs[3]) begin
            fu_res = sum[W-1:0];
            fu_c   = sum[W];
            fu_v   = (a_op[W-1] == add_y[W-1]) && (sum[W-1] != a_op[W-1]);
        end else begin
            case (fs[2:0])
                3'b000:  fu_res = a_op & b_sel;
                3'b001:  fu_res = a_op | b_sel;
                3'b010:  fu_res = a_op ^ b_sel;
                3'b011:  fu_res = ~a_op;
                3'b100:  fu_res = b_sel;
                3'b101:  fu_res = {1'b0, b_sel[W-1:1]};
                3'b110:  fu_res = {b_sel[W-2:0], 1'b0};
                default: fu_res = '0;
            endcase
        end
    end

    assign result = md ? data_in_mem : fu_res;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_data  <= '0;
            wb_valid <= 1'b0;
            wb_da    <= '0;
            wb_rw    <= 1'b0;
        end else begin
            wb_valid <= in_valid;
            if (in_valid) begin
                wb_data <= result;
                wb_da   <= da;
                wb_rw   <= rw;
            end
        end
    end

    // Flags track the function unit even when the write-back value is load data.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v <= 1'b0;
            c <= 1'b0;
            n <= 1'b0;
            z <= 1'b0;
        end else if (in_valid && fl_en) begin
            v <= fu_v;
            c <= fu_c;
            n <= fu_res[W-1];
            z <= (fu_res == '0);
        end
    end

    assign wb_we = wb_valid && wb_rw && !(R0_ZERO && (wb_da == '0));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                regs[i] <= '0;
            end
        end else if (wb_we) begin
            regs[wb_da] <= wb_data;
        end
    end
endmodule

// File: tb/tb_datapath_pipe.sv
// Randomised bench for datapath_pipe: two instances (R0_ZERO = 0 and 1) share stimulus and are scored against a cycle model.
module tb_datapath_pipe;
    localparam int W    = 8;
    localparam int AW   = 2;
    localparam int MOD  = 1 << W;
    localparam int HALF = 1 << (W - 1);

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic in_valid = 1'b0;
    logic rw = 1'b0;
    logic mb = 1'b0;
    logic md = 1'b0;
    logic fl_en = 1'b0;
    logic [AW-1:0] da = '0;
    logic [AW-1:0] aa = '0;
    logic [AW-1:0] ba = '0;
    logic [3:0]    fs = '0;
    logic [W-1:0]  constant_in = '0;
    logic [W-1:0]  data_in_mem = '0;

    logic [1:0][W-1:0] address_out;
    logic [1:0][W-1:0] data_out;
    logic [1:0][W-1:0] jump_address;
    logic [1:0][W-1:0] wb_data;
    logic [1:0]        wb_valid;
    logic [1:0]        v;
    logic [1:0]        c;
    logic [1:0]        n;
    logic [1:0]        z;

    int errors = 0;
    int checks = 0;

    // Reference state, one copy per instance; index 1 is the zero-register variant.
    logic [W-1:0]  mreg  [2][4];
    logic [W-1:0]  mwbd  [2];
    logic [AW-1:0] mwbda [2];
    logic          mwbrw [2];
    logic          mwbv  [2];
    logic [3:0]    mflag [2];
    logic [W+3:0]  fr    [2];

    always #5 clk = ~clk;

    datapath_pipe #(.W(W), .AW(AW), .R0_ZERO(1'b0)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rw(rw), .da(da), .aa(aa), .ba(ba),
        .mb(mb), .md(md), .fs(fs), .fl_en(fl_en), .constant_in(constant_in),
        .data_in_mem(data_in_mem), .address_out(address_out[0]), .data_out(data_out[0]),
        .jump_address(jump_address[0]), .wb_data(wb_data[0]), .wb_valid(wb_valid[0]),
        .v(v[0]), .c(c[0]), .n(n[0]), .z(z[0])
    );

    datapath_pipe #(.W(W), .AW(AW), .R0_ZERO(1'b1)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .rw(rw), .da(da), .aa(aa), .ba(ba),
        .mb(mb), .md(md), .fs(fs), .fl_en(fl_en), .constant_in(constant_in),
        .data_in_mem(data_in_mem), .address_out(address_out[1]), .data_out(data_out[1]),
        .jump_address(jump_address[1]), .wb_data(wb_data[1]), .wb_valid(wb_valid[1]),
        .v(v[1]), .c(c[1]), .n(n[1]), .z(z[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Returns {V, C, N, Z, result}, from integer arithmetic on unsigned and signed views.
    function automatic logic [W+3:0] ref_fu(input logic [W-1:0] a, input logic [W-1:0] b,
                                            input logic [3:0] f);
        int ua, ub, sa, sb, u, s;
        logic [W-1:0] r;
        logic cv, vv;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        u  = ua;
        s  = sa;
        r  = '0;
        cv = 1'b0;
        vv = 1'b0;
        case (f)
            4'h1: begin u = ua + 1;             s = sa + 1;      end
            4'h2: begin u = ua + ub;            s = sa + sb;     end
            4'h3: begin u = ua + ub + 1;        s = sa + sb + 1; end
            4'h4: begin u = ua + (MOD - 1 - ub); s = sa - sb - 1; end
            4'h5: begin u = ua + (MOD - ub);     s = sa - sb;     end
            4'h6: begin u = ua + (MOD - 1);      s = sa - 1;      end
            default: ;
        endcase
        if (!f[3]) begin
            r  = u[W-1:0];
            cv = u[W];
            vv = (s > HALF - 1) || (s < -HALF);
        end else begin
            case (f)
                4'h8: r = a & b;
                4'h9: r = a | b;
                4'hA: r = a ^ b;
                4'hB: r = ~a;
                4'hC: r = b;
                4'hD: r = b >> 1;
                4'hE: r = b << 1;
                default: r = '0;
            endcase
        end
        return {vv, cv, r[W-1], (r == '0), r};
    endfunction

    function automatic logic [W-1:0] ref_read(input int k, input logic [AW-1:0] s);
        if (k == 1 && s == '0) return '0;
        if (mwbv[k] && mwbrw[k] && mwbda[k] == s) return mwbd[k];
        return mreg[k][s];
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            for (int j = 0; j < 4; j++) mreg[k][j] = '0;
            mwbd[k]  = '0;
            mwbda[k] = '0;
            mwbrw[k] = 1'b0;
            mwbv[k]  = 1'b0;
            mflag[k] = '0;
        end
    endtask

    // One clock: drive, check combinational outputs, clock, advance model, check registered outputs.
    task automatic step(input logic t_iv, input logic t_rw, input logic [AW-1:0] t_da,
                        input logic [AW-1:0] t_aa, input logic [AW-1:0] t_ba,
                        input logic t_mb, input logic t_md, input logic [3:0] t_fs,
                        input logic t_fl, input logic [W-1:0] t_k, input logic [W-1:0] t_dm);
        logic [W-1:0] ea, eb;
        in_valid = t_iv; rw = t_rw; da = t_da; aa = t_aa; ba = t_ba;
        mb = t_mb; md = t_md; fs = t_fs; fl_en = t_fl; constant_in = t_k; data_in_mem = t_dm;
        #2;
        for (int k = 0; k < 2; k++) begin
            ea = ref_read(k, t_aa);
            eb = t_mb ? t_k : ref_read(k, t_ba);
            chk($sformatf("addr%0d", k), address_out[k], ea);
            chk($sformatf("jump%0d", k), jump_address[k], ea);
            chk($sformatf("dout%0d", k), data_out[k], eb);
            fr[k] = ref_fu(ea, eb, t_fs);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            if (mwbv[k] && mwbrw[k] && !(k == 1 && mwbda[k] == '0)) mreg[k][mwbda[k]] = mwbd[k];
            if (t_iv) begin
                mwbd[k]  = t_md ? t_dm : fr[k][W-1:0];
                mwbda[k] = t_da;
                mwbrw[k] = t_rw;
                mwbv[k]  = 1'b1;
                if (t_fl) mflag[k] = fr[k][W+3:W];
            end else begin
                mwbv[k] = 1'b0;
            end
            chk($sformatf("wbd%0d", k), wb_data[k], mwbd[k]);
            chk($sformatf("wbv%0d", k), wb_valid[k], mwbv[k]);
            chk($sformatf("flags%0d", k), {v[k], c[k], n[k], z[k]}, mflag[k]);
        end
    endtask

    // Reset pulse placed mid-cycle, released mid-cycle one clock later.
    task automatic do_reset();
        in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        model_reset();
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst_wbv%0d", k), wb_valid[k], 0);
            chk($sformatf("rst_wbd%0d", k), wb_data[k], 0);
            chk($sformatf("rst_flags%0d", k), {v[k], c[k], n[k], z[k]}, 0);
        end
        for (int j = 0; j < 4; j++) begin
            aa = 2'(j);
            #1;
            for (int k = 0; k < 2; k++) chk($sformatf("rst_reg%0d_%0d", k, j), address_out[k], 0);
        end
        @(posedge clk);
        #3 rst = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        #2;
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("init_wbv%0d", k), wb_valid[k], 0);
            chk($sformatf("init_flags%0d", k), {v[k], c[k], n[k], z[k]}, 0);
        end
        @(posedge clk);
        #3 rst = 1'b0;

        // R1 <= 0x7F, then R2 <= R1 + 1 through the forwarding path
        step(1, 1, 2'd1, 2'd0, 2'd0, 1, 0, 4'hC, 0, 8'h7F, 8'h00);
        step(1, 1, 2'd2, 2'd1, 2'd0, 0, 0, 4'h1, 1, 8'h00, 8'h00);
        chk("fwd_wb", wb_data[0], 8'h80);
        chk("fwd_flags", {v[0], c[0], n[0], z[0]}, 4'b1010);

        // 5 - 5 with flags loaded and no write, then flags held by a non-loading op
        step(1, 1, 2'd1, 2'd0, 2'd0, 1, 0, 4'hC, 0, 8'h05, 8'h00);
        step(1, 1, 2'd2, 2'd0, 2'd0, 1, 0, 4'hC, 0, 8'h05, 8'h00);
        step(1, 0, 2'd0, 2'd1, 2'd2, 0, 0, 4'h5, 1, 8'h00, 8'h00);
        chk("sub_flags", {v[0], c[0], n[0], z[0]}, 4'b0101);
        step(1, 0, 2'd0, 2'd1, 2'd2, 0, 0, 4'h2, 0, 8'h00, 8'h00);
        chk("hold_flags", {v[1], c[1], n[1], z[1]}, 4'b0101);
        chk("add_wb", wb_data[0], 8'h0A);

        // Load 0xA5 into R3, read it back from the register file two cycles later
        step(1, 1, 2'd3, 2'd2, 2'd0, 0, 1, 4'h0, 0, 8'h00, 8'hA5);
        step(0, 0, 2'd0, 2'd0, 2'd0, 0, 0, 4'h0, 0, 8'h00, 8'h00);
        step(1, 0, 2'd0, 2'd3, 2'd0, 0, 0, 4'h0, 0, 8'h00, 8'h00);
        chk("load_r3", wb_data[0], 8'hA5);

        // Write 0xFF to R0, read next cycle (forwarded) and two cycles later
        step(1, 1, 2'd0, 2'd0, 2'd0, 1, 0, 4'hC, 0, 8'hFF, 8'h00);
        step(1, 0, 2'd1, 2'd0, 2'd0, 0, 0, 4'h0, 0, 8'h00, 8'h00);
        chk("r0z_next", wb_data[1], 8'h00);
        chk("r0_next", wb_data[0], 8'hFF);
        step(1, 0, 2'd1, 2'd0, 2'd0, 0, 0, 4'h0, 0, 8'h00, 8'h00);
        chk("r0z_later", wb_data[1], 8'h00);
        chk("r0_later", wb_data[0], 8'hFF);

        // Reset while R2 <= 0x33 is pending in write-back
        step(1, 1, 2'd2, 2'd0, 2'd0, 1, 0, 4'hC, 0, 8'h33, 8'h00);
        chk("pend_wbv", wb_valid[0], 1);
        do_reset();
        step(1, 0, 2'd0, 2'd1, 2'd0, 0, 0, 4'h0, 0, 8'h00, 8'h00);
        chk("rst_r1_read", wb_data[0], 8'h00);
        step(1, 0, 2'd0, 2'd2, 2'd0, 0, 0, 4'h0, 0, 8'h00, 8'h00);
        chk("rst_r2_read", wb_data[1], 8'h00);

        for (int i = 0; i < 600; i++) begin
            if (i % 151 == 150) do_reset();
            step(($urandom % 4) != 0, 1'($urandom), 2'($urandom), 2'($urandom), 2'($urandom),
                 1'($urandom), ($urandom % 5) == 0, 4'($urandom), 1'($urandom),
                 8'($urandom), 8'($urandom));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
